operand_mux_pipe: RTL and testbench

OPERAND_MUX_PIPE -- requirements
Module: operand_mux_pipe

---
 rtl/operand_mux_pkg.sv | 6 +
 rtl/operand_sel.sv | 16 +
 rtl/operand_mux_pipe.sv | 86 ++++++++
 tb/tb_operand_mux_pipe.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/operand_mux_pkg.sv
// operand_mux_pkg: state encoding and error-counter sizing shared by the operand select pipeline.
package operand_mux_pkg;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
   localparam int ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
endpackage

// File: rtl/operand_sel.sv
// operand_sel: combinational N_IN-way word select, zero when the select is out of range.
module operand_sel #(
   parameter int WIDTH = 32,
   parameter int N_IN = 4,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic [N_IN*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]      sel_i,
   output logic [WIDTH-1:0]      word_o
);
   always_comb begin
      word_o = '0;
      for (int k = 0; k < N_IN; k++)
         if (32'(sel_i) == k) word_o = data_i[k*WIDTH +: WIDTH];
   end
endmodule

// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe: selects one of N_IN operands into a main+skid register pair with sticky illegal-select flag.
// Define OPERAND_MUX_PIPE_ERRCNT_EN to add the saturating err_cnt output.
module operand_mux_pipe
   import operand_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_IN = 4,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sel_err
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
   ,
   output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d, sel_word;
   logic             in_ready_q, sel_err_q, in_xfer, out_xfer, bad_sel;
   operand_sel #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W)) u_sel (
      .data_i(in_data),
      .sel_i (in_sel),
      .word_o(sel_word)
   );
   assign in_xfer   = in_valid && in_ready_q;
   assign out_xfer  = out_valid && out_ready;
   assign bad_sel   = in_xfer && (32'(in_sel) >= N_IN);
   // Masked during reset so no output transfer can complete in the reset cycle.
   assign out_valid = (state_q != EMPTY) && !rst;
   assign out_data  = main_q;
   assign in_ready  = in_ready_q;
   assign sel_err   = sel_err_q;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: if (in_xfer) begin
            state_d = ONE;
            main_d  = sel_word;
         end
         ONE: if (in_xfer && out_xfer) main_d = sel_word;
            else if (in_xfer) begin
               state_d = TWO;
               skid_d  = sel_word;
            end
            else if (out_xfer) state_d = EMPTY;
         TWO: if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
         sel_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= state_d != TWO;
         sel_err_q  <= sel_err_q | bad_sel;
      end
   end
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;
   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= '0;
      else if (bad_sel && err_cnt_q != ERR_CNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
   end
   assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_operand_mux_pipe.sv
// tb_operand_mux_pipe: directed checks of select, skid backpressure, streaming, reset and illegal-select flagging.
module tb_operand_mux_pipe;
   localparam int W = 32;
   localparam int N = 3;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N*W-1:0] in_data = '0;
   logic [1:0]     in_sel = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           sel_err;
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
   logic [7:0]     err_cnt;
`endif
   int checks = 0;
   int errors = 0;
   operand_mux_pipe #(.WIDTH(W), .N_IN(N)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .sel_err(sel_err)
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
`endif
   endtask
   task automatic test_select();
      logic [W-1:0] exp_w [2] = '{32'h11111111, 32'h22222222};
      out_ready = 1'b1;
      in_data = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
      in_sel = 2'd2;
      in_valid = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sel2_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sel2_data got %h exp deadbeef", out_data); end
      for (int s = 0; s < 2; s++) begin
         in_sel = 2'(s);
         tick();
         checks++; if (out_data !== exp_w[s]) begin errors++; $display("FAIL sel%0d_data got %h exp %h", s, out_data, exp_w[s]); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain got %b exp 0", out_valid); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL sel_legal_err got %b exp 0", sel_err); end
   endtask
   task automatic test_illegal();
      in_sel = 2'd3;
      in_valid = 1'b0;
      tick();
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL ignored_sel_err got %b exp 0", sel_err); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL illegal_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL illegal_data got %h exp 0", out_data); end
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL illegal_sel_err got %b exp 1", sel_err); end
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL illegal_err_cnt got %0d exp 1", err_cnt); end
`endif
      tick();
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sticky_sel_err got %b exp 1", sel_err); end
   endtask
   task automatic test_back_to_back();
      out_ready = 1'b0;
      in_sel = 2'd0;
      in_valid = 1'b1;
      in_data = {32'hBAD0BAD0, 32'hBAD1BAD1, 32'h00000001};
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
      in_data[31:0] = 32'h00000002;
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2 got %b exp 0", in_ready); end
      checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL bp_first got %h exp 1", out_data); end
      in_data[31:0] = 32'h00000003;
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3 got %b exp 0", in_ready); end
      checks++; if (out_data !== 32'h1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got %h/%b exp 1/1", out_data, out_valid); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_data !== 32'h2) begin errors++; $display("FAIL bp_second got %h exp 2", out_data); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_data !== 32'h3) begin errors++; $display("FAIL bp_third got %h exp 3", out_data); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
   endtask
   task automatic test_stream();
      int good = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      in_sel = 2'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_data[W +: W] = 32'(i + 1);
         tick();
         if (out_valid === 1'b1 && in_ready === 1'b1 && out_data === 32'(i + 1)) good++;
      end
      in_valid = 1'b0;
      checks++; if (good !== 100) begin errors++; $display("FAIL stream_in_order got %0d exp 100", good); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
   endtask
   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_sel = 2'd3;
      in_valid = 1'b1;
      tick();
      in_sel = 2'd0;
      in_data[31:0] = 32'h00000055;
      tick();
      checks++; if (in_ready !== 1'b0 || sel_err !== 1'b1) begin errors++; $display("FAIL two_state got %b/%b exp 0/1", in_ready, sel_err); end
      rst = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_cycle_valid got %b exp 0", out_valid); end
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", in_ready); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", out_data); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL mid_rst_sel_err got %b exp 0", sel_err); end
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_err_cnt got %0d exp 0", err_cnt); end
`endif
   endtask
   task automatic test_saturate();
      out_ready = 1'b1;
      in_sel = 2'd3;
      in_valid = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick();
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
         if (i == 254) begin
            checks++; if (err_cnt !== 8'd254) begin errors++; $display("FAIL cnt_254 got %0d exp 254", err_cnt); end
         end
`endif
      end
      in_valid = 1'b0;
`ifdef OPERAND_MUX_PIPE_ERRCNT_EN
      checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL cnt_sat got %0d exp 255", err_cnt); end
`endif
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sat_sel_err got %b exp 1", sel_err); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL sat_data got %h exp 0", out_data); end
   endtask
   initial begin
      test_reset();
      test_select();
      test_illegal();
      test_back_to_back();
      test_stream();
      test_reset_mid();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
